if_fetch_queue: RTL and testbench

Parametrised successor to the single-register instruction fetch stage. Decouples instruction memory from decode with a request/response memory port, up to MAX_OUTSTANDING in-flight reads and a QUEUE_DEPTH-entry instruction queue. Supports freeze, branch redirect with queue flush and discard of stale in-flight responses. Sits between the PC/branch logic of EX and the ID stage register.

---
 rtl/if_fetch_queue.sv | 147 ++++++++++++++
 tb/tb_if_fetch_queue.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// Instruction fetch with a request/response memory port, in-flight read tracking and an instruction queue toward ID.
// Define IF_PERF_CNT_EN to add the perf_fetch_cnt / perf_flush_cnt counter outputs.
module if_fetch_queue #(
  parameter int              ADDR_W          = 32,
  parameter int              INST_W          = 32,
  parameter int              QUEUE_DEPTH     = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [ADDR_W-1:0] RESET_PC      = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc_plus4,
  output logic [INST_W-1:0] out_inst
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  localparam int QI_W  = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = QI_W + 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int TI_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [QI_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [OUT_W-1:0]  outstanding_q, outstanding_d;
  logic [OUT_W-1:0]  discard_q, discard_d;
  logic [TI_W-1:0]   tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;

  logic [ADDR_W-1:0] q_pc4_q  [QUEUE_DEPTH];
  logic [INST_W-1:0] q_inst_q [QUEUE_DEPTH];
  logic [ADDR_W-1:0] tag_q    [MAX_OUTSTANDING];

  logic accept, rsp_live, drop, enq, deq, credit_ok, slot_ok, not_empty;

  function automatic logic [TI_W-1:0] tag_inc(input logic [TI_W-1:0] p);
    return (p == TI_W'(MAX_OUTSTANDING - 1)) ? '0 : p + TI_W'(1);
  endfunction

  // Both ports are valid/ready: a transfer happens in the cycle where valid and ready are both high.
  // The credit check reserves a queue slot for every in-flight read, so an accepted response always fits.
  always_comb begin
    not_empty = (count_q != '0);
    credit_ok = (32'(count_q) + 32'(outstanding_q)) < 32'(QUEUE_DEPTH);
    slot_ok   = 32'(outstanding_q) < 32'(MAX_OUTSTANDING);
    imem_req  = rst & ~branch_taken & ~freeze & slot_ok & credit_ok;
    imem_addr = fetch_pc_q;
    accept    = imem_req & imem_ready;
    rsp_live  = imem_rvalid & (outstanding_q != '0);
    drop      = rsp_live & ((discard_q != '0) | branch_taken);
    enq       = rsp_live & ~drop;
    out_valid = not_empty & ~freeze;
    deq       = out_valid & out_ready & ~branch_taken;
    out_pc_plus4 = not_empty ? q_pc4_q[head_q]  : '0;
    out_inst     = not_empty ? q_inst_q[head_q] : '0;
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    count_d       = count_q;
    head_d        = head_q;
    tail_d        = tail_q;
    discard_d     = discard_q;
    tag_wr_d      = tag_wr_q;
    tag_rd_d      = tag_rd_q;
    outstanding_d = outstanding_q + OUT_W'(accept) - OUT_W'(rsp_live);
    if (accept) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      tag_wr_d   = tag_inc(tag_wr_q);
    end
    if (rsp_live) tag_rd_d = tag_inc(tag_rd_q);
    if (enq) tail_d = tail_q + QI_W'(1);
    if (branch_taken) begin
      // Everything still in flight after this cycle belongs to the old path.
      fetch_pc_d = branch_addr;
      count_d    = '0;
      head_d     = tail_q;
      discard_d  = outstanding_q - OUT_W'(rsp_live);
    end else begin
      count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
      if (deq) head_d = head_q + QI_W'(1);
      if (rsp_live && (discard_q != '0)) discard_d = discard_q - OUT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q    <= RESET_PC;
      count_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      tag_wr_q      <= '0;
      tag_rd_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      count_q       <= count_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      tag_wr_q      <= tag_wr_d;
      tag_rd_q      <= tag_rd_d;
    end
  end

  // Payload storage needs no reset: outputs are gated by the count.
  always_ff @(posedge clk) begin
    if (accept) tag_q[tag_wr_q] <= fetch_pc_q;
    if (enq) begin
      q_pc4_q[tail_q]  <= tag_q[tag_rd_q] + ADDR_W'(4);
      q_inst_q[tail_q] <= imem_rdata;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_flush_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_q + 32'(deq);
      perf_flush_q <= perf_flush_q + 32'(branch_taken);
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: variable-latency memory model, in-order dequeue scoreboard and directed checks.
module tb_if_fetch_queue;

  logic        clk = 1'b0;
  logic        rst, freeze, branch_taken, imem_ready, imem_rvalid, out_ready;
  logic [31:0] branch_addr, imem_rdata;
  logic        imem_req, out_valid;
  logic [31:0] imem_addr, out_pc_plus4, out_inst;

  int vectors     = 0;
  int miscompares = 0;
  int deq_cnt     = 0;
  int acc_cnt     = 0;
  int lat         = 1;
  int cyc_n       = 0;

  logic [63:0] exp_q[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  if_fetch_queue dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc_plus4 (out_pc_plus4),
    .out_inst     (out_inst)
  );

  // clock: negedge at multiples of 10, posedge 5 later
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[31:16]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #2;
  endtask

  task automatic push_stream(input logic [31:0] base, input int n);
    logic [31:0] a;
    exp_q.delete();
    for (int k = 0; k < n; k++) begin
      a = base + 32'(4 * k);
      exp_q.push_back({a + 32'd4, inst_of(a)});
    end
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (!out_valid && n < budget) begin
      cyc();
      n++;
    end
  endtask

  task automatic wait_pend(input int want, input int budget);
    int n;
    n = 0;
    while (pend_addr.size() != want && n < budget) begin
      cyc();
      n++;
    end
  endtask

  // memory model: in-order responses lat cycles after acceptance
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      cyc_n++;
      if (pend_due.size() > 0 && pend_due[0] <= cyc_n) begin
        imem_rvalid = 1'b1;
        imem_rdata  = inst_of(pend_addr[0]);
        void'(pend_due.pop_front());
        void'(pend_addr.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
      end
      #4;
      if (imem_req && imem_ready) begin
        pend_addr.push_back(imem_addr);
        pend_due.push_back(cyc_n + lat);
        acc_cnt++;
      end
    end
  end

  // scoreboard: every dequeue must match the head of exp_q
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      #4;
      if (rst && out_valid && out_ready && !freeze && !branch_taken) begin
        deq_cnt++;
        check("deq_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("deq_pc4", out_pc_plus4, e[63:32]);
          check("deq_inst", out_inst, e[31:0]);
        end
      end
    end
  end

  initial begin
    int d0;
    rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
    imem_ready = 1'b1; out_ready = 1'b0;
    cyc(); cyc();
    #1;
    check("rst_req", imem_req, 0);
    check("rst_valid", out_valid, 0);
    check("rst_inst", out_inst, 0);
    check("rst_pc4", out_pc_plus4, 0);

    // fill with consumer stalled: exactly QUEUE_DEPTH reads accepted
    push_stream(32'h0, 128);
    cyc();
    rst = 1'b1;
    #1;
    check("a_req", imem_req, 1);
    check("a_addr", imem_addr, 32'h0);
    repeat (20) cyc();
    #1;
    check("a_acc_cnt", acc_cnt, 4);
    check("a_req_off", imem_req, 0);
    check("a_valid", out_valid, 1);
    check("a_pc4", out_pc_plus4, 32'h4);
    check("a_inst", out_inst, inst_of(32'h0));

    // drain, then one instruction per cycle
    cyc();
    out_ready = 1'b1;
    repeat (12) cyc();
    d0 = deq_cnt;
    repeat (8) cyc();
    check("b_rate", deq_cnt - d0, 8);

    // redirect with two stale reads in flight at 3-cycle latency
    lat = 3;
    repeat (10) cyc();
    wait_pend(2, 20);
    check("c_two_inflight", pend_addr.size(), 2);
    branch_taken = 1'b1;
    branch_addr  = 32'h100;
    push_stream(32'h100, 128);
    #1;
    check("c_req_blocked", imem_req, 0);
    cyc();
    branch_taken = 1'b0;
    wait_valid(20);
    check("c_valid", out_valid, 1);
    check("c_pc4", out_pc_plus4, 32'h104);
    check("c_inst", out_inst, inst_of(32'h100));

    // minimum redirect latency with 1-cycle memory
    lat = 1;
    repeat (10) cyc();
    branch_taken = 1'b1;
    branch_addr  = 32'h40;
    push_stream(32'h40, 128);
    cyc();
    branch_taken = 1'b0;
    #1;
    check("d_valid_t1", out_valid, 0);
    check("d_req_t1", imem_req, 1);
    check("d_addr_t1", imem_addr, 32'h40);
    cyc();
    #1;
    check("d_valid_t2", out_valid, 0);
    cyc();
    #1;
    check("d_valid_t3", out_valid, 1);
    check("d_pc4_t3", out_pc_plus4, 32'h44);

    // freeze with responses pending
    lat = 3;
    repeat (10) cyc();
    check("e_pending", 32'(pend_addr.size() != 0), 1);
    freeze = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("e_frz_valid", out_valid, 0);
      check("e_frz_req", imem_req, 0);
      cyc();
    end
    check("e_drained", pend_addr.size(), 0);
    freeze = 1'b0;
    #1;
    check("e_valid_back", out_valid, 1);

    // PC wrap at the top of the address space
    lat = 1;
    repeat (10) cyc();
    branch_taken = 1'b1;
    branch_addr  = 32'hFFFF_FFFC;
    push_stream(32'hFFFF_FFFC, 128);
    cyc();
    branch_taken = 1'b0;
    #1;
    check("f_req0", imem_req, 1);
    check("f_addr0", imem_addr, 32'hFFFF_FFFC);
    cyc();
    #1;
    check("f_req1", imem_req, 1);
    check("f_addr1", imem_addr, 32'h0);
    cyc();
    #1;
    check("f_valid", out_valid, 1);
    check("f_pc4", out_pc_plus4, 32'h0);
    check("f_inst", out_inst, inst_of(32'hFFFF_FFFC));

    // asynchronous reset with one read still in flight
    lat = 3;
    repeat (10) cyc();
    wait_pend(1, 20);
    check("g_one_inflight", pend_addr.size(), 1);
    rst = 1'b0;
    imem_ready = 1'b0;
    push_stream(32'h0, 128);
    #1;
    check("g_req", imem_req, 0);
    check("g_valid", out_valid, 0);
    check("g_inst", out_inst, 0);
    check("g_pc4", out_pc_plus4, 0);
    check("g_addr", imem_addr, 32'h0);
    cyc();
    rst = 1'b1;
    wait_pend(0, 10);
    check("g_late_gone", pend_addr.size(), 0);
    cyc();
    #1;
    check("g_late_ignored", out_valid, 0);
    imem_ready = 1'b1;
    wait_valid(20);
    check("g_restart_valid", out_valid, 1);
    check("g_restart_pc4", out_pc_plus4, 32'h4);
    check("g_restart_inst", out_inst, inst_of(32'h0));
    repeat (6) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
